// File: rtl/rysy_uart_pkg.sv
// -----------------------------------------------------------------------------
// rysy_uart_pkg
// Shared definitions for the rysy UART transmitter peripheral:
//   - register word indices (addr[1:0])
//   - STATUS register bit positions
//   - transmitter FSM state type
//   - divisor helper (a programmed divisor of 0 behaves as 1)
// -----------------------------------------------------------------------------
package rysy_uart_pkg;

    // Register word indices, decoded from addr[1:0]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    // STATUS register bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 8;

    // Transmitter frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // A zero divisor would stall the bit counter, so it is treated as 1
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        logic [15:0] res;
        if (div == 16'd0) begin
            res = 16'd1;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// -----------------------------------------------------------------------------
// uart_tx_periph_if
// Core-side bus bundle shared with the GPIO-style peripherals.
//   addr  [7:0]  word address (core addr[9:2])
//   be    [3:0]  byte enables for writes
//   wdata [31:0] write data
//   we           write strobe, already qualified for this peripheral
//   q     [31:0] registered read data returned to the interconnect
// master: interconnect side, slave: peripheral side.
// -----------------------------------------------------------------------------
interface uart_tx_periph_if;

    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] q;

    modport master (
        output addr,
        output be,
        output wdata,
        output we,
        input  q
    );

    modport slave (
        input  addr,
        input  be,
        input  wdata,
        input  we,
        output q
    );

endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead output (dout is the current head while
// not empty). Pushes while full and pops while empty are ignored. A pop in
// the same cycle as a push on a full FIFO does not make room for the push.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (contents discarded)
//   push, din     write request and data
//   pop           remove the head entry
//   dout          head entry
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the occupancy seen at this edge
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == CW'(0));
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        dout      = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Storage array; data needs no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter. Bytes written to DATA are queued in a
// small FIFO and shifted out LSB first on tx at DIV clock cycles per bit.
// Register map (addr[1:0]): 0 DATA (wo, reads 0), 1 STATUS, 2 DIV (rw),
// 3 reserved (reads 0).
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset; forces tx high immediately
//   bus   core-side slave bundle (addr, be, wdata, we in; registered q out)
//   tx    serial output, idle high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx_periph
    import rysy_uart_pkg::*;
#(
    parameter int DIV_RESET  = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_periph_if.slave bus,
    output logic            tx
);

    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

    // Register state
    logic [15:0]  div_r;
    logic         overrun_r;
    logic [31:0]  q_r;

    // Transmitter state
    uart_state_t  state_r;
    logic [7:0]   shift_r;
    logic [15:0]  bit_cnt_r;
    logic [2:0]   bit_idx_r;
    logic         tx_r;

    // Decode and datapath
    logic [1:0]   reg_idx_s;
    logic         data_wr_s;
    logic         ovr_clr_s;
    logic         ovr_set_s;
    logic         div_wr_lo_s;
    logic         div_wr_hi_s;
    logic [15:0]  div_eff_s;
    logic [15:0]  bit_reload_s;
    logic         bit_done_s;
    logic         pop_s;
    logic [31:0]  status_s;
    logic [31:0]  rdata_s;

    // FIFO interface
    logic [7:0]   fifo_dout_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic [CW-1:0] fifo_count_s;

    // Bus bits that are intentionally not decoded
    logic         unused_s;
    assign unused_s = ^{bus.addr[7:2], bus.be[3:2], bus.wdata[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr_s),
        .din   (bus.wdata[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Write decode: only addr[1:0] selects a register
    always_comb begin
        reg_idx_s   = bus.addr[1:0];
        data_wr_s   = 1'b0;
        ovr_clr_s   = 1'b0;
        div_wr_lo_s = 1'b0;
        div_wr_hi_s = 1'b0;
        if (bus.we) begin
            data_wr_s   = bus.be[0] && (reg_idx_s == REG_DATA);
            ovr_clr_s   = bus.be[0] && (reg_idx_s == REG_STATUS) && bus.wdata[ST_OVERRUN];
            div_wr_lo_s = bus.be[0] && (reg_idx_s == REG_DIV);
            div_wr_hi_s = bus.be[1] && (reg_idx_s == REG_DIV);
        end else begin
            data_wr_s   = 1'b0;
            ovr_clr_s   = 1'b0;
            div_wr_lo_s = 1'b0;
            div_wr_hi_s = 1'b0;
        end
        // A push into a full FIFO is dropped by the FIFO and flagged here
        ovr_set_s = data_wr_s && fifo_full_s;
    end

    // Bit timing and head-of-queue pop decision
    always_comb begin
        div_eff_s    = eff_div(div_r);
        bit_reload_s = div_eff_s - 16'd1;
        bit_done_s   = (bit_cnt_r == 16'd0);
        case (state_r)
            IDLE:    pop_s = !fifo_empty_s;
            STOP:    pop_s = bit_done_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // STATUS word assembly and read mux
    always_comb begin
        status_s                              = 32'd0;
        status_s[ST_BUSY]                     = (state_r != IDLE) || !fifo_empty_s;
        status_s[ST_FULL]                     = fifo_full_s;
        status_s[ST_EMPTY]                    = fifo_empty_s;
        status_s[ST_OVERRUN]                  = overrun_r;
        status_s[ST_COUNT_MSB:ST_COUNT_LSB]   = 5'(fifo_count_s);
        case (reg_idx_s)
            REG_DATA:   rdata_s = 32'd0;
            REG_STATUS: rdata_s = status_s;
            REG_DIV:    rdata_s = {16'd0, div_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Divisor register (byte-wise) and sticky overrun flag; set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= DIV_INIT;
            overrun_r <= 1'b0;
        end else begin
            if (div_wr_lo_s) begin
                div_r[7:0] <= bus.wdata[7:0];
            end
            if (div_wr_hi_s) begin
                div_r[15:8] <= bus.wdata[15:8];
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Registered read data, sampled every cycle with no side effects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= 32'd0;
        end else begin
            q_r <= rdata_s;
        end
    end

    // Frame FSM: the bit counter reloads from DIV at every bit boundary, so
    // a divisor change takes effect on the next bit, never mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= 8'd0;
            bit_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r   <= fifo_dout_s;
                        bit_cnt_r <= bit_reload_s;
                        state_r   <= START;
                        tx_r      <= 1'b0;
                    end else begin
                        tx_r      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                        bit_idx_r <= 3'd0;
                        bit_cnt_r <= bit_reload_s;
                        state_r   <= DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        bit_cnt_r <= bit_reload_s;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        if (pop_s) begin
                            // Back-to-back frame: start bit follows stop bit directly
                            shift_r   <= fifo_dout_s;
                            bit_cnt_r <= bit_reload_s;
                            state_r   <= START;
                            tx_r      <= 1'b0;
                        end else begin
                            state_r   <= IDLE;
                            tx_r      <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.q = q_r;
    assign tx    = tx_r;

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
// Self-checking bench for uart_tx_periph: register-access vector table,
// hand-written frame/timing sequences, and randomized traffic checked against
// a frame-schedule reference model (start time of every accepted byte is
// derived from write times, divisor and FIFO depth).
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam int FDEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx;

    uart_tx_periph_if bus ();

    uart_tx_periph #(
        .DIV_RESET  (434),
        .FIFO_DEPTH (FDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic tx_hist [int];

    // reference model state
    int         w_edge [$];
    logic [7:0] w_byte [$];
    int         m_start [$];
    logic [7:0] m_byte [$];
    int         m_div;
    bit         m_over;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        tx_hist[cyc] = tx;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        bus.addr  = a;
        bus.be    = b;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
        bus.be    = 4'h0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        bus.addr = a;
        bus.we   = 1'b0;
        tick();
        v = bus.q;
    endtask

    task automatic do_reset();
        bus.we = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
    endtask

    // Frame schedule: a byte is dropped if FDEPTH entries are waiting at its
    // write edge; an accepted byte starts at max(end of previous frame, write+1)
    task automatic model_schedule();
        int occ;
        int prev_end;
        int s;
        m_start.delete();
        m_byte.delete();
        m_over = 1'b0;
        for (int i = 0; i < w_edge.size(); i++) begin
            occ = 0;
            for (int j = 0; j < m_start.size(); j++) begin
                if (m_start[j] >= w_edge[i]) occ++;
            end
            if (occ >= FDEPTH) begin
                m_over = 1'b1;
            end else begin
                prev_end = (m_start.size() > 0) ? m_start[m_start.size()-1] + 10 * m_div : 0;
                s = (prev_end > w_edge[i] + 1) ? prev_end : w_edge[i] + 1;
                m_start.push_back(s);
                m_byte.push_back(w_byte[i]);
            end
        end
    endtask

    function automatic logic exp_tx(input int c);
        logic r;
        int   pos;
        r = 1'b1;
        for (int k = 0; k < m_start.size(); k++) begin
            if (c >= m_start[k] && c < m_start[k] + 10 * m_div) begin
                pos = (c - m_start[k]) / m_div;
                if (pos == 0)      r = 1'b0;
                else if (pos == 9) r = 1'b1;
                else               r = m_byte[k][pos-1];
            end
        end
        return r;
    endfunction

    task automatic check_wave(input string name, input int from, input int to);
        int errs;
        int first;
        logic e;
        errs  = 0;
        first = -1;
        for (int c = from; c <= to; c++) begin
            e = exp_tx(c);
            if (tx_hist[c] !== e) begin
                errs++;
                if (first < 0) first = c;
            end
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL %s: %0d tx cycles differ, first at cycle %0d got %b expected %b",
                     name, errs, first, tx_hist[first], exp_tx(first));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [9:0]  frame;
        logic [7:0]  pat;
        logic [7:0]  b;
        logic        e;
        int          n0;
        int          errs;
        int          d;
        int          eff;
        int          n;
        int          g;
        int          last;

        rst       = 1'b1;
        bus.addr  = 8'h00;
        bus.be    = 4'h0;
        bus.wdata = 32'h0;
        bus.we    = 1'b0;
        tick();
        tick();
        chk("reset_tx", 32'(tx), 32'h1);
        chk("reset_q", bus.q, 32'h0);
        rst = 1'b0;

        // ---------------- register access table ----------------
        vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 8'h01, 4'h0, 32'h00000000, 32'h00000004});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 32'h00000000, 32'h000001B2});
        vecs.push_back('{1'b0, 8'h03, 4'h0, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b1, 8'h02, 4'h3, 32'hFFFF1234, 32'h000001B2});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 32'h00000000, 32'h00001234});
        vecs.push_back('{1'b1, 8'h02, 4'h1, 32'h000000AB, 32'h00001234});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 32'h00000000, 32'h000012AB});
        vecs.push_back('{1'b1, 8'h02, 4'hC, 32'hFFFFFFFF, 32'h000012AB});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 32'h00000000, 32'h000012AB});
        vecs.push_back('{1'b1, 8'h03, 4'hF, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{1'b0, 8'h03, 4'h0, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b1, 8'h02, 4'h2, 32'h00000100, 32'h000012AB});
        vecs.push_back('{1'b0, 8'h02, 4'h0, 32'h00000000, 32'h000001AB});
        vecs.push_back('{1'b1, 8'h01, 4'h1, 32'h00000008, 32'h00000004});
        vecs.push_back('{1'b0, 8'h01, 4'h0, 32'h00000000, 32'h00000004});
        vecs.push_back('{1'b0, 8'h02, 4'hF, 32'h00000000, 32'h000001AB});
        vecs.push_back('{1'b0, 8'hFE, 4'h0, 32'h00000000, 32'h000001AB});
        vecs.push_back('{1'b0, 8'h05, 4'h0, 32'h00000000, 32'h00000004});
        vecs.push_back('{1'b1, 8'h00, 4'hE, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{1'b0, 8'h01, 4'h0, 32'h00000000, 32'h00000004});
        for (int i = 0; i < vecs.size(); i++) begin
            bus.we    = vecs[i].we;
            bus.addr  = vecs[i].addr;
            bus.be    = vecs[i].be;
            bus.wdata = vecs[i].wdata;
            tick();
            chk($sformatf("regvec%0d", i), bus.q, vecs[i].exp_q);
        end
        bus.we = 1'b0;
        chk("idle_tx", 32'(tx), 32'h1);

        // ---------------- single frame 0xA5, DIV=4 ----------------
        wr(8'h02, 4'h3, 32'd4);
        wr(8'h00, 4'h1, 32'h000000A5);
        frame    = {1'b1, 8'hA5, 1'b0};
        bus.addr = 8'h01;
        for (int j = 1; j <= 44; j++) begin
            tick();
            e = (j <= 40) ? frame[(j-1)/4] : 1'b1;
            chk($sformatf("a5_tx_%0d", j), 32'(tx), 32'(e));
            chk($sformatf("a5_busy_%0d", j), 32'(bus.q[0]), (j <= 41) ? 32'h1 : 32'h0);
        end
        rd(8'h01, v);
        chk("a5_status_after", v, 32'h00000004);

        // ---------------- back-to-back frames, DIV=2 ----------------
        wr(8'h02, 4'h3, 32'd2);
        w_edge.delete();
        w_byte.delete();
        wr(8'h00, 4'h1, 32'h11); w_edge.push_back(cyc); w_byte.push_back(8'h11);
        wr(8'h00, 4'h1, 32'h22); w_edge.push_back(cyc); w_byte.push_back(8'h22);
        wr(8'h00, 4'h1, 32'h33); w_edge.push_back(cyc); w_byte.push_back(8'h33);
        rd(8'h01, v);
        chk("b2b_status_count2", v, 32'h00000021);
        m_div = 2;
        model_schedule();
        chk("b2b_contiguous", 32'(m_start[2] - m_start[0]), 32'd40);
        last = m_start[m_start.size()-1] + 10 * m_div;
        while (cyc < last + 2) tick();
        check_wave("b2b_wave", w_edge[0], last + 1);

        // ---------------- overrun with DIV=100 ----------------
        wr(8'h02, 4'h3, 32'd100);
        for (int k = 0; k < 6; k++) wr(8'h00, 4'h1, 32'(8'h40 + k));
        rd(8'h01, v);
        chk("ovr_status", v, 32'h0000004B);
        wr(8'h01, 4'h1, 32'h00000008);
        rd(8'h01, v);
        chk("ovr_cleared", v, 32'h00000043);
        do_reset();
        rd(8'h01, v);
        chk("ovr_reset_status", v, 32'h00000004);

        // ---------------- DIV change mid-frame (4 -> 8 in bit 3) ----------------
        wr(8'h02, 4'h3, 32'd4);
        pat = 8'h55;
        wr(8'h00, 4'h1, 32'(pat));
        n0 = cyc;
        while (cyc < n0 + 17) tick();
        wr(8'h02, 4'h3, 32'd8);
        while (cyc < n0 + 63) tick();
        errs = 0;
        for (int c = n0 + 1; c <= n0 + 62; c++) begin
            if (c < n0 + 5)       e = 1'b0;
            else if (c < n0 + 21) e = pat[(c - n0 - 5) / 4];
            else if (c < n0 + 53) e = pat[4 + (c - n0 - 21) / 8];
            else                  e = 1'b1;
            if (tx_hist[c] !== e) errs++;
        end
        chk("divchg_bad_cycles", 32'(errs), 32'd0);

        // ---------------- reset during data bit 5 ----------------
        wr(8'h02, 4'h3, 32'd4);
        wr(8'h00, 4'h1, 32'h00000000);
        n0 = cyc;
        while (cyc < n0 + 26) tick();
        chk("rst_pre_tx", 32'(tx), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        rd(8'h01, v);
        chk("rst_status", v, 32'h00000004);
        rd(8'h02, v);
        chk("rst_div", v, 32'h000001B2);
        errs = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (tx !== 1'b1) errs++;
        end
        chk("rst_no_frame", 32'(errs), 32'd0);

        // ---------------- randomized traffic vs. schedule model ----------------
        for (int it = 0; it < 20; it++) begin
            d     = $urandom_range(0, 5);
            eff   = (d == 0) ? 1 : d;
            m_div = eff;
            wr(8'h02, 4'h3, 32'(d));
            wr(8'h01, 4'h1, 32'h00000008);
            w_edge.delete();
            w_byte.delete();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                g = $urandom_range(0, 12 * eff);
                repeat (g) tick();
                b = 8'($urandom);
                wr({6'($urandom), 2'b00}, 4'h1, {24'($urandom), b});
                w_edge.push_back(cyc);
                w_byte.push_back(b);
            end
            model_schedule();
            last = m_start[m_start.size()-1] + 10 * m_div;
            while (cyc < last + 2) tick();
            check_wave($sformatf("rand%0d_wave", it), w_edge[0], last + 1);
            rd(8'h01, v);
            chk($sformatf("rand%0d_status", it), v, m_over ? 32'h0000000C : 32'h00000004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
